xcore_pipe_ctrl: RTL
====================

# xcore_pipe_ctrl

Pipeline sequencing controller for the Xcore 5-stage integer pipeline (IF, ID, EX, MEM, WB). It drives the load-enable and hold controls of the four inter-stage pipeline registers plus the WB latch, and tracks a per-stage valid bit. It resolves load-use stalls, multi-cycle EX operations, branch redirects and traps. It sits between the decoder/EX/MEM hazard sources and the general load-enable registers. Those registers clear to zero when lden is low, and hold via datapath recirculation when hold is high.

## Interface
- MCW, 6: width of multi-cycle length input.
- FLUSH_CYC, 2: fetch-squash cycles after a redirect or trap (1..7).
- SCW, 16: stall performance counter width.

- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high. One clock; reset is asynchronous and active-high.
- ifu_rdy  in  1  fetch presents an instruction this cycle.
- lu_hzd  in  1  load-use hazard detected in ID.
- mc_start  in  1  EX issues a multi-cycle op.
- mc_len  in  MCW  total stall cycles for that op.
- br_redir  in  1  taken branch/jump resolved in EX.
- exc_req  in  1  trap raised by the MEM instruction.
- stg_lden  out  5  per-stage load enable, bit0=IF/ID … bit4=WB; 0 = capture bubble.
- stg_hold  out  5  per-stage hold; meaningful only with lden=1; the datapath recirculates the register output.
- stg_vld  out  5  registered valid per stage.
- pc_sel  out  2  00 sequential, 01 branch target, 10 trap vector.
- stall_o  out  1  any stage held this cycle.
- flush_o  out  1  redirect, trap or squash active.
- stall_cnt  out  SCW  saturating count of stall_o cycles.

## Operation
- FSM states: RUN, MCBUSY. A down-counter mc_cnt (MCW bits) and a squash counter sq_cnt (3 bits) are kept independent of the FSM.
- Priority in every cycle: exc_req > br_redir > MCBUSY > mc_start > lu_hzd > normal advance.
- Normal advance: lden=11111, hold=00000.
- lu_hzd (RUN only): lden=11011, hold=00011. IF and ID hold, EX takes a bubble, MEM and WB advance. Single cycle, no state change.
- mc_start in RUN with mc_len=N:
  - N=0: ignored.
  - N≥1: the issue cycle is stall 1. If N>1, go to MCBUSY with mc_cnt=N-2.
  - In MCBUSY: lden=10111, hold=00111. mc_cnt decrements each cycle; leave MCBUSY to RUN in the cycle mc_cnt=0.
  - Issue-cycle controls are the same as MCBUSY.
  - mc_start in MCBUSY is ignored.
- br_redir: lden=11100, hold=0, pc_sel=01, sq_cnt loaded with FLUSH_CYC. Ignored in MCBUSY, where EX is occupied; the bench asserts it never occurs there.
- exc_req: lden=10000, hold=0, pc_sel=10. FSM goes to RUN with mc_cnt=0 (aborts multi-cycle) and sq_cnt=FLUSH_CYC.
- Squash: while sq_cnt≠0, the IF valid source is forced to 0 and sq_cnt decrements. This runs in either FSM state.
- Valid chain: vld[i] next = lden[i] ? (hold[i] ? vld[i] : src[i]) : 0.
  - src[0] = ifu_rdy & (sq_cnt==0).
  - src[i] = vld[i-1].
- stall_o = |stg_hold.
- flush_o = br_redir_taken | exc_req | (sq_cnt≠0).
- stall_cnt increments when stall_o=1 and saturates at all-ones.

## Timing
- stg_lden, stg_hold, pc_sel, stall_o and flush_o are combinational from state and current inputs, so they affect capture in the same edge.
- stg_vld, state, mc_cnt, sq_cnt and stall_cnt are registered.
- Reset values: state=RUN; mc_cnt=0; sq_cnt=0; stg_vld=00000; stall_cnt=0. While reset is high, stg_lden=00000, stg_hold=00000, pc_sel=00, stall_o=0 and flush_o=0.
- Reset mid-MCBUSY or mid-squash returns everything to the reset values immediately. After release, the first edge follows normal RUN rules.
- Simultaneous br_redir+mc_start: redirect wins and the op is not started.
- Simultaneous lu_hzd+br_redir: redirect wins.
- exc_req in the last MCBUSY cycle: trap wins, and the next state is RUN.

## Structure
- Package xcore_pipe_pkg holds:
  - the state enum (RUN, MCBUSY);
  - stage index constants (STG_IF=0 … STG_WB=4);
  - pc_sel encodings (PCS_SEQ, PCS_BR, PCS_TRAP);
  - the fixed lden/hold patterns as named constants.
- One sub-module, xcore_pipe_vldchain: the 5-bit valid register chain, driven by lden/hold/src0.

## Test plan
- Reset, then ifu_rdy=1 for 6 cycles -> stg_vld goes 00001, 00011, 00111, 01111, 11111, 11111; lden=11111; stall_cnt=0.
- Full pipe, lu_hzd for 1 cycle -> that cycle lden=11011, hold=00011, stall_o=1; next cycle stg_vld=11011; stall_cnt=1.
- mc_start with mc_len=3 -> stall_o high for exactly 3 cycles (lden=10111, hold=00111); state RUN on the 4th; stall_cnt=3.
- br_redir with FLUSH_CYC=2 and ifu_rdy held 1 -> pc_sel=01, lden=11100; flush_o high 3 cycles; stg_vld[0]=0 for 3 edges, 1 on the 4th.
- exc_req during MCBUSY (mc_cnt=2), plus br_redir in the same cycle -> pc_sel=10, lden=10000; next state RUN with mc_cnt=0; stg_vld[3:0]=0000.
- reset asserted mid-MCBUSY -> outputs immediately at reset values; after release, mc_len=1 gives a 1-cycle stall only.

Source files
------------

// File: rtl/xcore_pipe_pkg.sv
// Shared types and constants for the Xcore pipeline sequencing controller:
// FSM states, stage indices, pc_sel encodings and the fixed lden/hold patterns.
package xcore_pipe_pkg;

   typedef enum logic {RUN, MCBUSY} pipe_state_t;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;
   localparam int NUM_STG = 5;

   localparam logic [1:0] PCS_SEQ  = 2'b00;
   localparam logic [1:0] PCS_BR   = 2'b01;
   localparam logic [1:0] PCS_TRAP = 2'b10;

   // Bit i of each pattern controls the register feeding stage i+1 (bit0 = IF/ID).
   localparam logic [NUM_STG-1:0] LDEN_RUN  = '1;
   localparam logic [NUM_STG-1:0] HOLD_NONE = '0;
   localparam logic [NUM_STG-1:0] LDEN_LU   = ~(5'(1) << STG_EX);
   localparam logic [NUM_STG-1:0] HOLD_LU   = (5'(1) << STG_IF) | (5'(1) << STG_ID);
   localparam logic [NUM_STG-1:0] LDEN_MC   = ~(5'(1) << STG_MEM);
   localparam logic [NUM_STG-1:0] HOLD_MC   = HOLD_LU | (5'(1) << STG_EX);
   localparam logic [NUM_STG-1:0] LDEN_BR   = ~HOLD_LU;
   localparam logic [NUM_STG-1:0] LDEN_TRAP = 5'(1) << STG_WB;

endpackage

// File: rtl/xcore_pipe_vldchain.sv
// Per-stage valid bits: each stage clears on a bubble, keeps its bit on hold,
// otherwise inherits the valid bit of the stage in front of it.
module xcore_pipe_vldchain
   import xcore_pipe_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_STG-1:0] lden,
   input  logic [NUM_STG-1:0] hold,
   input  logic               src0,
   output logic [NUM_STG-1:0] vld
);

   logic [NUM_STG-1:0] src;

   assign src = {vld[STG_WB-1:STG_IF], src0};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         vld <= '0;
      else
         vld <= lden & ((hold & vld) | (~hold & src));
   end

endmodule

// File: rtl/xcore_pipe_ctrl.sv
// Xcore 5-stage pipeline sequencing controller: resolves traps, redirects,
// multi-cycle EX ops and load-use stalls into per-stage lden/hold controls.
module xcore_pipe_ctrl
   import xcore_pipe_pkg::*;
#(
   parameter int MCW       = 6,
   parameter int FLUSH_CYC = 2,
   parameter int SCW       = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ifu_rdy,
   input  logic           lu_hzd,
   input  logic           mc_start,
   input  logic [MCW-1:0] mc_len,
   input  logic           br_redir,
   input  logic           exc_req,
   output logic [4:0]     stg_lden,
   output logic [4:0]     stg_hold,
   output logic [4:0]     stg_vld,
   output logic [1:0]     pc_sel,
   output logic           stall_o,
   output logic           flush_o,
   output logic [SCW-1:0] stall_cnt
);

   pipe_state_t    state, state_next;
   logic [MCW-1:0] mc_cnt, mc_next;
   logic [2:0]     sq_cnt;
   logic           br_taken;
   logic           src0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= RUN;
         mc_cnt <= '0;
      end else begin
         state  <= state_next;
         mc_cnt <= mc_next;
      end
   end

   // Priority chain: trap, redirect (RUN only), busy multi-cycle, issue, load-use.
   always_comb begin
      state_next = state;
      mc_next    = mc_cnt;
      stg_lden   = LDEN_RUN;
      stg_hold   = HOLD_NONE;
      pc_sel     = PCS_SEQ;
      br_taken   = 1'b0;
      if (reset) begin
         stg_lden = '0;
      end else if (exc_req) begin
         stg_lden   = LDEN_TRAP;
         pc_sel     = PCS_TRAP;
         state_next = RUN;
         mc_next    = '0;
      end else if (br_redir && state == RUN) begin
         br_taken = 1'b1;
         stg_lden = LDEN_BR;
         pc_sel   = PCS_BR;
      end else if (state == MCBUSY) begin
         stg_lden = LDEN_MC;
         stg_hold = HOLD_MC;
         if (mc_cnt == '0)
            state_next = RUN;
         else
            mc_next = mc_cnt - MCW'(1);
      end else if (mc_start && mc_len != '0) begin
         stg_lden = LDEN_MC;
         stg_hold = HOLD_MC;
         if (mc_len > MCW'(1)) begin
            state_next = MCBUSY;
            mc_next    = mc_len - MCW'(2);
         end
      end else if (lu_hzd) begin
         stg_lden = LDEN_LU;
         stg_hold = HOLD_LU;
      end
   end

   // Squash window keeps fetch from marking instructions valid after a redirect or trap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sq_cnt <= '0;
      else if (exc_req || br_taken)
         sq_cnt <= 3'(FLUSH_CYC);
      else if (sq_cnt != '0)
         sq_cnt <= sq_cnt - 3'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall_o && stall_cnt != '1)
         stall_cnt <= stall_cnt + SCW'(1);
   end

   assign src0    = ifu_rdy & (sq_cnt == '0);
   assign stall_o = |stg_hold;
   assign flush_o = br_taken | (exc_req & ~reset) | (sq_cnt != '0);

   xcore_pipe_vldchain u_vldchain (
      .clk   (clk),
      .reset (reset),
      .lden  (stg_lden),
      .hold  (stg_hold),
      .src0  (src0),
      .vld   (stg_vld)
   );

endmodule
